// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that puts a fetch port and a data port onto one
// fixed-latency memory window; accesses outside the window complete at once with an error.
module mem_arbiter #(
  parameter int          WAIT = 1,
  parameter logic [63:0] BASE = 64'h8000_0000,
  parameter int          AW   = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [63:0]   i_addr,
  output logic          i_ack,
  output logic [63:0]   i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic [63:0]   d_addr,
  input  logic [63:0]   d_wdata,
  input  logic          d_rw,
  input  logic [1:0]    d_word,
  output logic          d_ack,
  output logic [63:0]   d_rdata,
  output logic          d_err,
  output logic          m_cs,
  output logic [AW-1:0] m_addr,
  output logic [63:0]   m_wdata,
  output logic          m_we,
  output logic [1:0]    m_word,
  input  logic [63:0]   m_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [63:0] LIMIT    = BASE + ((64'd1 << AW) - 64'd1);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic          last_data;
  logic          src_data;
  logic [AW-1:0] lat_addr;
  logic [63:0]   lat_wdata;
  logic          lat_rw;
  logic [1:0]    lat_word;

  logic          grant_data;
  logic [63:0]   sel_addr;
  logic          in_window;

  // On a tie the data port wins only when fetch was the previous grant.
  always_comb begin
    grant_data = 1'b0;
    if (d_req && (!i_req || !last_data)) grant_data = 1'b1;
    sel_addr  = grant_data ? d_addr : i_addr;
    in_window = (sel_addr >= BASE) && (sel_addr <= LIMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_data <= 1'b1;
      src_data  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rw    <= 1'b0;
      lat_word  <= '0;
      i_ack     <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            last_data <= grant_data;
            src_data  <= grant_data;
            lat_addr  <= sel_addr[AW-1:0] - BASE[AW-1:0];
            lat_wdata <= grant_data ? d_wdata : 64'd0;
            lat_rw    <= grant_data & d_rw;
            lat_word  <= grant_data ? d_word : 2'b10;
            if (in_window) begin
              state <= ACCESS;
              cnt   <= CNT_INIT;
            end else begin
              // Out-of-window requests skip memory entirely and answer next cycle.
              state <= RESP;
              if (grant_data) begin
                d_ack   <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                i_ack   <= 1'b1;
                i_err   <= 1'b1;
                i_rdata <= '0;
              end
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            if (src_data) begin
              d_ack   <= 1'b1;
              d_err   <= 1'b0;
              d_rdata <= lat_rw ? 64'd0 : m_rdata;
            end else begin
              i_ack   <= 1'b1;
              i_err   <= 1'b0;
              i_rdata <= m_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes are decoded from state so an asynchronous reset drops them immediately.
  assign m_cs    = (state == ACCESS);
  assign m_we    = (state == ACCESS) && (cnt == 4'd0) && lat_rw;
  assign m_addr  = lat_addr;
  assign m_wdata = lat_wdata;
  assign m_word  = lat_word;
  assign busy    = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WAIT, 1, memory access cycles per transaction (legal 1..15).
REQ-002 Parameter: BASE, 64'h80000000, first byte address of the memory window.
REQ-003 Parameter: AW, 12, memory window address width (window = 2^AW bytes).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 i_req  in  1  fetch request (read-only requester).
REQ-007 i_addr  in  64  fetch byte address.
REQ-008 i_ack  out  1  one-cycle fetch completion pulse.
REQ-009 i_rdata  out  64  fetch read data, valid while i_ack=1.
REQ-010 i_err  out  1  fetch address outside window, valid while i_ack=1.
REQ-011 d_req  in  1  data request.
REQ-012 d_addr  in  64  data byte address.
REQ-013 d_wdata  in  64  store data.
REQ-014 d_rw  in  1  1=store, 0=load.
REQ-015 d_word  in  2  access size code, passed through unchanged.
REQ-016 d_ack / d_rdata / d_err  out  1/64/1  as i_ack / i_rdata / i_err, for the data port.
REQ-017 m_cs  out  1  memory select.
REQ-018 m_addr  out  AW  memory offset (request address minus BASE).
REQ-019 m_wdata  out  64  memory write data.
REQ-020 m_we  out  1  memory write enable.
REQ-021 m_word  out  2  memory size code (fetch forces 2'b10).
REQ-022 m_rdata  in  64  memory read data, combinational from m_addr.
REQ-023 busy  out  1  high in any state other than IDLE.

Function
REQ-024 States: IDLE, ACCESS, RESP; all outputs are registered or decoded from the state/latch registers only.
REQ-025 IDLE: if any req is high, select a winner, latch its addr/wdata/rw/word/source, and proceed; otherwise stay.
REQ-026 Arbitration is round-robin: on simultaneous i_req and d_req, grant the port not granted last; a lone requester is always granted.
REQ-027 The last-grant pointer updates only on a grant, including error grants.
REQ-028 In-window test: BASE <= addr <= BASE+2^AW-1, as a 64-bit unsigned compare.
REQ-029 In-window grant: IDLE -> ACCESS, with the wait counter loaded to WAIT-1.
REQ-030 Out-of-window grant: IDLE -> RESP directly, with err=1, rdata=0, and m_cs never asserted.
REQ-031 ACCESS: m_cs=1, m_addr/m_wdata/m_word from latches; counter decrements each cycle; exit when counter=0.
REQ-032 m_we=1 only in the final ACCESS cycle and only for a store; never asserted for fetch.
REQ-033 In the final ACCESS cycle, capture m_rdata into the granted port's rdata register; stores capture 0.
REQ-034 RESP: the granted port's ack=1 for exactly one cycle, the other port's ack=0; next state is IDLE.
REQ-035 Latency: request sampled in IDLE at cycle N gives ack at N+WAIT+1 in-window, or N+1 out-of-window.
REQ-036 Throughput: at most one transaction per WAIT+2 cycles, because IDLE always intervenes.
REQ-037 Requesters hold req and operands until ack; a req dropped mid-transaction does not abort it, and the ack still pulses.
REQ-038 A req still high in the IDLE cycle after its own ack is treated as a new request.
REQ-039 rdata/err hold their last values between acks.
REQ-040 Outside ACCESS: m_cs=0, m_we=0; m_addr/m_wdata/m_word hold the latches.

Reset
REQ-041 rst=0 forces, immediately and asynchronously, state=IDLE, all acks/err=0, m_cs=0, m_we=0, busy=0, rdata=0, latches=0, counter=0, last-grant=data (so the first contested grant goes to fetch).
REQ-042 Reset during ACCESS aborts the transaction: no ack is issued and no write occurs after rst falls.

Verification
REQ-043 Fetch only, WAIT=1, i_addr=0x80000010, m_rdata=0x1234 -> m_cs high 1 cycle, m_addr=0x010, m_word=2'b10, i_ack at N+2 with i_rdata=0x1234, i_err=0.
REQ-044 i_req and d_req together from reset, held, WAIT=2 -> grant order fetch, data, fetch, data; acks spaced 4 cycles apart; never both acks in one cycle.
REQ-045 Store d_addr=0x80000FF8, d_wdata=0xDEAD, WAIT=3 -> m_cs high 3 cycles, m_we high only in the 3rd, d_ack at N+4, d_rdata=0.
REQ-046 d_addr=0x02001000 load -> no m_cs, d_ack at N+1, d_err=1, d_rdata=0; boundary check: 0x7FFFFFFF and 0x80001000 err, 0x80000000 no err.
REQ-047 rst pulled low during ACCESS of a store with WAIT=4 -> m_cs and m_we drop immediately, no d_ack; after rst release, a new fetch completes normally.
